// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU interrupt interface: signal codes, the
// host command format and the beat expansion used by the command initiator.
package gpu_pkg;

    // Interrupt codes understood by the gpu block.
    localparam logic [1:0] SIG_STORE_BYTE  = 2'b00;
    localparam logic [1:0] SIG_MOVE_CURSOR = 2'b01;
    localparam logic [1:0] SIG_DISPLAY     = 2'b10;
    localparam logic [1:0] SIG_CLEAR       = 2'b11;

    typedef enum logic [1:0] {
        OP_RAW   = 2'b00,
        OP_PUTC  = 2'b01,
        OP_FLIP  = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } tx_state_t;

    // One queued host command (18 bits).
    typedef struct packed {
        cmd_op_t    op;
        logic [7:0] data;
        logic [7:0] attr;
    } cmd_t;

    // First interrupt beat of a command, plus whether a second beat follows.
    typedef struct packed {
        logic [1:0] code;
        logic [7:0] data;
        logic       second;
    } beat_t;

    // Expands a command into its first beat. Only PUTC has a second beat,
    // which always carries the shade byte as another STORE_BYTE.
    function automatic beat_t first_beat(input cmd_t cmd);
        beat_t b;
        b.code   = SIG_CLEAR;
        b.data   = 8'h00;
        b.second = 1'b0;
        case (cmd.op)
            OP_RAW: begin
                b.code = cmd.attr[1:0];
                b.data = cmd.data;
            end
            OP_PUTC: begin
                b.code   = SIG_STORE_BYTE;
                b.data   = cmd.data;
                b.second = 1'b1;
            end
            OP_FLIP: begin
                b.code = SIG_DISPLAY;
            end
            default: begin
                b.code = SIG_CLEAR;
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. The head word is read straight
// from storage at the read pointer, so it is valid whenever empty_o is low.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full refuses pushes for the whole cycle, even if a pop happens too.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through this block can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of block order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the count and pointers alone decide which words are live.
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/gpu_cmd_tx.sv
// CPU-side initiator for the gpu interrupt interface. Queues display
// commands and plays each out as one or two timed interrupt beats:
// code/data set up, enable strobed, code/data held, all from registers.
module gpu_cmd_tx
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [7:0]                    cmd_data,
    input  logic [7:0]                    cmd_attr,
    output logic [1:0]                    interrupt_code_out,
    output logic [7:0]                    interrupt_data_out,
    output logic                          interrupt_enable_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // One down-counter serves all three phases; size it for the longest.
    localparam int MAX_SS  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_CYC = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             second_q, second_d;
    logic [7:0]       beat1_q, beat1_d;

    cmd_t             push_cmd;
    cmd_t             head_cmd;
    beat_t            head_beat;
    logic [$bits(cmd_t)-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic             take_head;

    // Pack the host fields into the queued command word.
    always_comb begin
        push_cmd.op   = cmd_op_t'(cmd_op);
        push_cmd.data = cmd_data;
        push_cmd.attr = cmd_attr;
    end

    sync_fifo #(
        .WIDTH (18),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .wdata_i (push_cmd),
        .pop_i   (take_head),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_cmd  = cmd_t'(fifo_rdata);
    assign head_beat = first_beat(head_cmd);
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

    assign interrupt_code_out   = code_q;
    assign interrupt_data_out   = data_q;
    assign interrupt_enable_out = en_q;

    // Beat sequencer: next state, counter and output register values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        data_d    = data_q;
        en_d      = en_q;
        second_d  = second_q;
        beat1_d   = beat1_q;
        take_head = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take_head = !fifo_empty;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    en_d    = 1'b1;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (second_q) begin
                    // Shade byte of a PUTC follows the glyph without a gap.
                    state_d  = ST_SETUP;
                    cnt_d    = SETUP_LOAD;
                    code_d   = SIG_STORE_BYTE;
                    data_d   = beat1_q;
                    second_d = 1'b0;
                end else if (!fifo_empty) begin
                    take_head = 1'b1;
                end else begin
                    // Code/data keep their last values while idle.
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Popping a command loads its first beat onto the outputs at once.
        if (take_head) begin
            state_d  = ST_SETUP;
            cnt_d    = SETUP_LOAD;
            code_d   = head_beat.code;
            data_d   = head_beat.data;
            second_d = head_beat.second;
            beat1_d  = head_cmd.attr;
        end
    end

    // Sequencer and output registers; reset drops the enable on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            code_q   <= 2'b00;
            data_q   <= 8'h00;
            en_q     <= 1'b0;
            second_q <= 1'b0;
            beat1_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            data_q   <= data_d;
            en_q     <= en_d;
            second_q <= second_d;
            beat1_q  <= beat1_d;
        end
    end

endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Self-checking bench for gpu_cmd_tx: a scoreboard of expected interrupt
// beats, a strobe monitor with a tiny gpu text model, and directed timing
// checks on a default instance and a SETUP=3/STROBE=1/HOLD=2 instance.
module tb_gpu_cmd_tx;
    import gpu_pkg::*;

    typedef struct {
        logic [1:0] code;
        logic [7:0] data;
    } exp_beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Default-parameter instance.
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] cmd_attr = 8'h00;
    logic [1:0] irq_code;
    logic [7:0] irq_data;
    logic       irq_en;
    logic       busy;
    logic [2:0] fifo_count;

    // Long-setup instance.
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_op = 2'b00;
    logic [7:0] b_data = 8'h00;
    logic [7:0] b_attr = 8'h00;
    logic [1:0] b_code;
    logic [7:0] b_dout;
    logic       b_en;
    logic       b_busy;
    logic [2:0] b_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    exp_beat_t exp_q [$];
    int         cyc = 0;
    int         last_rise_cyc = 0;
    int         n_rises = 0;
    bit         gap_chk = 1'b0;
    bit         gap_armed = 1'b0;
    logic       en_prev = 1'b0;
    logic [1:0] code_prev = 2'b00;
    logic [7:0] data_prev = 8'h00;
    logic [1:0] code_hi = 2'b00;
    logic [7:0] data_hi = 8'h00;
    int         hi_len = 0;
    logic [7:0] text_mem [16];
    int         cursor = 0;

    gpu_cmd_tx dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_data             (cmd_data),
        .cmd_attr             (cmd_attr),
        .interrupt_code_out   (irq_code),
        .interrupt_data_out   (irq_data),
        .interrupt_enable_out (irq_en),
        .busy                 (busy),
        .fifo_count           (fifo_count)
    );

    gpu_cmd_tx #(
        .FIFO_DEPTH    (4),
        .SETUP_CYCLES  (3),
        .STROBE_CYCLES (1),
        .HOLD_CYCLES   (2)
    ) dut_b (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (b_valid),
        .cmd_ready            (b_ready),
        .cmd_op               (b_op),
        .cmd_data             (b_data),
        .cmd_attr             (b_attr),
        .interrupt_code_out   (b_code),
        .interrupt_data_out   (b_dout),
        .interrupt_enable_out (b_en),
        .busy                 (b_busy),
        .fifo_count           (b_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference expansion of one command into the beats the gpu should see.
    task automatic push_expected(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a);
        case (op)
            2'b00: exp_q.push_back('{code: a[1:0], data: d});
            2'b01: begin
                exp_q.push_back('{code: 2'b00, data: d});
                exp_q.push_back('{code: 2'b00, data: a});
            end
            2'b10: exp_q.push_back('{code: 2'b10, data: 8'h00});
            default: exp_q.push_back('{code: 2'b11, data: 8'h00});
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a);
        int waited = 0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_attr  = a;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            push_expected(op, d, a);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int waited = 0;
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) check(tag, 32'(busy), 32'd0);
    endtask

    // Strobe monitor for the default instance: scoreboard, timing, gpu model.
    always @(negedge clk) begin
        if (rst) begin
            en_prev = 1'b0;
            hi_len  = 0;
        end else begin
            if (irq_en && !en_prev) begin
                n_rises++;
                check("setup_code", 32'(irq_code), 32'(code_prev));
                check("setup_data", 32'(irq_data), 32'(data_prev));
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    exp_beat_t e;
                    e = exp_q.pop_front();
                    check("beat_code", 32'(irq_code), 32'(e.code));
                    check("beat_data", 32'(irq_data), 32'(e.data));
                end
                if (gap_chk && gap_armed) check("beat_period", cyc - last_rise_cyc, 32'd4);
                gap_armed     = gap_chk;
                last_rise_cyc = cyc;
                if (irq_code == SIG_STORE_BYTE && cursor < 16) begin
                    text_mem[cursor] = irq_data;
                    cursor++;
                end
                hi_len  = 1;
                code_hi = irq_code;
                data_hi = irq_data;
            end else if (irq_en) begin
                hi_len++;
                check("strobe_code", 32'(irq_code), 32'(code_hi));
                check("strobe_data", 32'(irq_data), 32'(data_hi));
            end else if (en_prev) begin
                check("strobe_width", hi_len, 32'd2);
                check("hold_code", 32'(irq_code), 32'(code_hi));
                check("hold_data", 32'(irq_data), 32'(data_hi));
            end
            en_prev = irq_en;
        end
        code_prev = irq_code;
        data_prev = irq_data;
    end

    initial begin
        int acc;
        int rises0;
        logic [2:0] exp_cnt [5];

        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2;
        exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd4;
        for (int i = 0; i < 16; i++) text_mem[i] = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_code", 32'(irq_code), 32'd0);
        check("rst_data", 32'(irq_data), 32'd0);
        check("rst_en", 32'(irq_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_b_en", 32'(b_en), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // FLIP into an idle block.
        push_cmd(2'b10, 8'h5A, 8'hC3);
        acc = cyc;
        repeat (4) @(negedge clk);
        check("flip_busy_in_hold", 32'(busy), 32'd1);
        @(negedge clk);
        check("flip_busy_after", 32'(busy), 32'd0);
        check("flip_rise_delay", last_rise_cyc - acc, 32'd2);
        check("flip_idle_code_kept", 32'(irq_code), 32'(SIG_DISPLAY));
        check("flip_idle_data", 32'(irq_data), 32'd0);

        // PUTC lands glyph then shade at consecutive cursor cells.
        cursor = 0;
        rises0 = n_rises;
        gap_chk = 1'b1;
        gap_armed = 1'b0;
        push_cmd(2'b01, 8'h41, 8'h1F);
        wait_idle("putc_idle_timeout");
        gap_chk = 1'b0;
        check("putc_strobes", n_rises - rises0, 32'd2);
        check("putc_text0", 32'(text_mem[0]), 32'h41);
        check("putc_text1", 32'(text_mem[1]), 32'h1F);
        check("putc_cursor", cursor, 32'd2);
        @(negedge clk);

        // Back-to-back RAW fill, full refusal during a pop, push+pop at 3.
        rises0 = n_rises;
        gap_chk = 1'b1;
        gap_armed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(2'b00, 8'h81 + 8'(i), 8'h01);
            check("fill_count", 32'(fifo_count), 32'(exp_cnt[i]));
        end
        check("full_ready_low", 32'(cmd_ready), 32'd0);
        cmd_op = 2'b00; cmd_data = 8'h86; cmd_attr = 8'h01; cmd_valid = 1'b1;
        @(negedge clk);
        check("full_push_refused", 32'(fifo_count), 32'd3);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("count_before_pushpop", 32'(fifo_count), 32'd3);
        check("ready_before_pushpop", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        push_expected(2'b00, 8'h86, 8'h01);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pushpop_count", 32'(fifo_count), 32'd3);
        wait_idle("raw_idle_timeout");
        gap_chk = 1'b0;
        check("raw_strobes", n_rises - rises0, 32'd6);
        check("raw_last_data", 32'(irq_data), 32'h86);
        @(negedge clk);

        // Reset in the second strobe cycle of a PUTC with two queued.
        push_cmd(2'b01, 8'h42, 8'h2E);
        push_cmd(2'b00, 8'h91, 8'h01);
        push_cmd(2'b00, 8'h92, 8'h01);
        @(negedge clk);
        check("pre_rst_en", 32'(irq_en), 32'd1);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_en", 32'(irq_en), 32'd0);
        check("midrst_code", 32'(irq_code), 32'd0);
        check("midrst_data", 32'(irq_data), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rises0 = n_rises;
        repeat (20) @(negedge clk);
        check("midrst_no_strobes", n_rises - rises0, 32'd0);
        check("midrst_still_idle", 32'(busy), 32'd0);

        // Long-setup instance: CLEAR gives a 1-cycle pulse 4 cycles after accept.
        check("b_ready", 32'(b_ready), 32'd1);
        b_op = 2'b11; b_data = 8'h77; b_attr = 8'h33; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("b_en_c%0d", k), 32'(b_en), (k == 4) ? 32'd1 : 32'd0);
            if (k <= 6) begin
                check($sformatf("b_code_c%0d", k), 32'(b_code), 32'(SIG_CLEAR));
                check($sformatf("b_data_c%0d", k), 32'(b_dout), 32'd0);
            end
        end
        check("b_idle_after", 32'(b_busy), 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
